// File: rtl/hapara_axis_id_gen_2d.sv
// 2-D work-group ID sweep over AXI4-Stream, X fastest, TDEST round-robin.
// Optional terminator beat: define HAPARA_IDGEN_TERM_EN.
module hapara_axis_id_gen_2d #(
    parameter int ID_WIDTH   = 16,
    parameter int NUM_DEST   = 4,
    parameter int DEST_WIDTH = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    cfg_wr_en,
    input  logic [1:0]              cfg_addr,
    input  logic [2*ID_WIDTH-1:0]   cfg_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [2*ID_WIDTH-1:0]   m_axis_tdata,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int DW = 2 * ID_WIDTH;
    localparam logic [DEST_WIDTH-1:0] LAST_DEST = DEST_WIDTH'(NUM_DEST - 1);

    typedef enum logic [1:0] {IDLE, RUN, TERM, DONE} state_t;

`ifdef HAPARA_IDGEN_TERM_EN
    localparam state_t END_STATE = TERM;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t state, stateNxt;

    logic [ID_WIDTH-1:0]   orgX, orgY, lenX, lenY;
    logic [ID_WIDTH-1:0]   shX, shY, shLx, cntX, cntY;
    logic [DW-1:0]         lastBeat, beatCnt;
    logic [DEST_WIDTH-1:0] destCnt;
    logic                  start, zeroLen, hs, runLast;

    assign start   = cfg_wr_en && (cfg_addr == 2'd2) && cfg_wdata[0];
    assign zeroLen = (lenX == '0) || (lenY == '0);
    assign hs      = m_axis_tvalid && m_axis_tready;
    assign runLast = (state == RUN) && (beatCnt == lastBeat);
    assign busy    = (state != IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (start) stateNxt = zeroLen ? END_STATE : RUN;
            RUN:     if (hs && runLast) stateNxt = END_STATE;
            TERM:    if (hs) stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Beat contents are derived from held counters, so they stay stable under stall.
    always_comb begin
        m_axis_tvalid = (state == RUN) || (state == TERM);
        m_axis_tlast  = runLast || (state == TERM);
        m_axis_tdata  = '0;
        m_axis_tdest  = '0;
        if (state == RUN) begin
            m_axis_tdata = {shY + cntY, shX + cntX};
            m_axis_tdest = destCnt;
        end else if (state == TERM) begin
            m_axis_tdata = '1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            orgX     <= '0;
            orgY     <= '0;
            lenX     <= '0;
            lenY     <= '0;
            shX      <= '0;
            shY      <= '0;
            shLx     <= '0;
            cntX     <= '0;
            cntY     <= '0;
            lastBeat <= '0;
            beatCnt  <= '0;
            destCnt  <= '0;
            done     <= 1'b0;
        end else begin
            if (state == IDLE && cfg_wr_en) begin
                case (cfg_addr)
                    2'd0:    {orgY, orgX} <= cfg_wdata;
                    2'd1:    {lenY, lenX} <= cfg_wdata;
                    default: ;
                endcase
            end
            // Shadow the configuration so host writes cannot disturb a sweep.
            if (state == IDLE && start) begin
                shX      <= orgX;
                shY      <= orgY;
                shLx     <= lenX;
                lastBeat <= DW'(lenX) * DW'(lenY) - DW'(1);
                cntX     <= '0;
                cntY     <= '0;
                beatCnt  <= '0;
                destCnt  <= '0;
                done     <= 1'b0;
            end
            if (state == RUN && hs) begin
                beatCnt <= beatCnt + DW'(1);
                if (cntX == shLx - ID_WIDTH'(1)) begin
                    cntX <= '0;
                    cntY <= cntY + ID_WIDTH'(1);
                end else begin
                    cntX <= cntX + ID_WIDTH'(1);
                end
                destCnt <= (destCnt == LAST_DEST) ? '0 : destCnt + DEST_WIDTH'(1);
            end
            if (state != DONE && stateNxt == DONE) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hapara_axis_id_gen_2d.sv
// Bench for hapara_axis_id_gen_2d: queue-based beat model plus literal sequence checks.
module tb_hapara_axis_id_gen_2d;

    localparam int ND = 4;
`ifdef HAPARA_IDGEN_TERM_EN
    localparam int TERM_EXTRA = 1;
`else
    localparam int TERM_EXTRA = 0;
`endif

    logic        tb_ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        busy, done;
    logic [31:0] m_axis_tdata;
    logic [1:0]  m_axis_tdest;
    logic        m_axis_tvalid, m_axis_tlast;
    logic        m_axis_tready;

    hapara_axis_id_gen_2d #(.ID_WIDTH(16), .NUM_DEST(ND), .DEST_WIDTH(2)) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .busy(busy), .done(done),
        .m_axis_tdata(m_axis_tdata), .m_axis_tdest(m_axis_tdest),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  dest;
        logic        last;
    } beat_t;

    int          checks = 0, errors = 0, hsCount = 0;
    bit          toggleMode = 1'b0;
    beat_t       expQ[$];
    logic [31:0] logD[$];
    logic [1:0]  logT[$];
    logic [31:0] mOrg, mLen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beats computed directly from the sweep definition.
    task automatic pushSweep();
        int    lx, ly, n;
        beat_t b;
        lx = int'(mLen[15:0]);
        ly = int'(mLen[31:16]);
        n  = lx * ly;
        for (int k = 0; k < n; k++) begin
            b.d[15:0]  = mOrg[15:0]  + 16'(k % lx);
            b.d[31:16] = mOrg[31:16] + 16'(k / lx);
            b.dest     = 2'(k % ND);
            b.last     = (k == n - 1);
            expQ.push_back(b);
        end
        if (TERM_EXTRA != 0) begin
            b.d = 32'hFFFF_FFFF; b.dest = 2'd0; b.last = 1'b1;
            expQ.push_back(b);
        end
    endtask

    // Callers are positioned 1 time unit after a rising edge.
    task automatic cfgWrite(input logic [1:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge tb_ACLK); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic startSweep();
        pushSweep();
        cfgWrite(2'd2, 32'd1);
    endtask

    task automatic waitDone(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge tb_ACLK);
            if (done && !busy) break;
        end
        chk({name, "_done"}, {62'd0, done, busy}, 64'd2);
        chk({name, "_drained"}, 64'(expQ.size()), 64'd0);
        @(posedge tb_ACLK); #1;
    endtask

    task automatic clearLog();
        logD.delete();
        logT.delete();
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge tb_ACLK); #1;
            m_axis_tready = toggleMode ? ~m_axis_tready : 1'b1;
        end
    end

    // Every presented beat must equal the model head; a handshake retires it.
    always @(negedge tb_ACLK) begin
        if (!ARESET && m_axis_tvalid) begin
            if (expQ.size() == 0) begin
                chk("unexpected_beat", {32'd0, m_axis_tdata}, 64'd0);
            end else begin
                chk("beat_data", {32'd0, m_axis_tdata}, {32'd0, expQ[0].d});
                chk("beat_dest", {62'd0, m_axis_tdest}, {62'd0, expQ[0].dest});
                chk("beat_last", {63'd0, m_axis_tlast}, {63'd0, expQ[0].last});
                if (m_axis_tready) begin
                    void'(expQ.pop_front());
                    logD.push_back(m_axis_tdata);
                    logT.push_back(m_axis_tdest);
                    hsCount++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] lit1 [6] = '{32'h00020010, 32'h00020011, 32'h00020012,
                              32'h00030010, 32'h00030011, 32'h00030012};
    logic [1:0]  litT [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] lit3 [4] = '{32'h0007FFFE, 32'h0007FFFF, 32'h00070000, 32'h00070001};

    initial begin
        int base;
        repeat (2) @(posedge tb_ACLK);
        #1;
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        chk("rst_done",   {63'd0, done}, 64'd0);
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_tlast",  {63'd0, m_axis_tlast}, 64'd0);
        chk("rst_tdata",  {32'd0, m_axis_tdata}, 64'd0);
        chk("rst_tdest",  {62'd0, m_axis_tdest}, 64'd0);
        ARESET = 1'b0;
        @(posedge tb_ACLK); #1;

        // 1: basic 3x2 sweep
        mOrg = 32'h0002_0010; mLen = 32'h0002_0003;
        cfgWrite(2'd0, mOrg); cfgWrite(2'd1, mLen);
        clearLog();
        startSweep();
        chk("s1_busy", {63'd0, busy}, 64'd1);
        chk("s1_done_low", {63'd0, done}, 64'd0);
        waitDone("s1", 50);
        chk("s1_count", 64'(logD.size()), 64'(6 + TERM_EXTRA));
        for (int i = 0; i < 6; i++) if (i < logD.size()) begin
            chk("s1_lit_data", {32'd0, logD[i]}, {32'd0, lit1[i]});
            chk("s1_lit_dest", {62'd0, logT[i]}, {62'd0, litT[i]});
        end

        // 2: same config, toggling tready
        clearLog();
        base = hsCount;
        toggleMode = 1'b1;
        startSweep();
        chk("s2_done_cleared", {63'd0, done}, 64'd0);
        waitDone("s2", 100);
        toggleMode = 1'b0;
        chk("s2_handshakes", 64'(hsCount - base), 64'(6 + TERM_EXTRA));
        for (int i = 0; i < 6; i++) if (i < logD.size())
            chk("s2_lit_data", {32'd0, logD[i]}, {32'd0, lit1[i]});

        // 3: x wraps modulo 2**16
        mOrg = 32'h0007_FFFE; mLen = 32'h0001_0004;
        cfgWrite(2'd0, mOrg); cfgWrite(2'd1, mLen);
        clearLog();
        startSweep();
        waitDone("s3", 50);
        for (int i = 0; i < 4; i++) if (i < logD.size())
            chk("s3_lit_wrap", {32'd0, logD[i]}, {32'd0, lit3[i]});

        // 4: zero-length sweep
        mLen = 32'h0000_0005;
        cfgWrite(2'd1, mLen);
        clearLog();
        startSweep();
`ifdef HAPARA_IDGEN_TERM_EN
        waitDone("s4", 50);
        chk("s4_term_count", 64'(logD.size()), 64'd1);
        if (logD.size() > 0) chk("s4_term_data", {32'd0, logD[0]}, 64'hFFFF_FFFF);
`else
        @(negedge tb_ACLK);
        chk("s4_done_fast", {63'd0, done}, 64'd1);
        waitDone("s4", 2);
        chk("s4_no_beats", 64'(logD.size()), 64'd0);
`endif

        // 5: config writes and start during RUN are dropped
        mOrg = 32'h0002_0010; mLen = 32'h0002_0003;
        cfgWrite(2'd0, mOrg); cfgWrite(2'd1, mLen);
        startSweep();
        cfgWrite(2'd0, 32'h0055_0055);
        cfgWrite(2'd2, 32'd1);
        cfgWrite(2'd1, 32'h0001_0001);
        waitDone("s5", 50);
        clearLog();
        startSweep();
        waitDone("s5b", 50);
        chk("s5_count", 64'(logD.size()), 64'(6 + TERM_EXTRA));
        if (logD.size() > 0) chk("s5_org_kept", {32'd0, logD[0]}, 64'h0002_0010);

        // 6: reset mid-sweep
        base = hsCount;
        startSweep();
        for (int i = 0; i < 50; i++) begin
            if (hsCount - base >= 3) break;
            @(posedge tb_ACLK); #1;
        end
        chk("s6_three_hs", 64'(hsCount - base), 64'd3);
        ARESET = 1'b1;
        @(posedge tb_ACLK); #1;
        expQ.delete();
        chk("s6_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("s6_busy",   {63'd0, busy}, 64'd0);
        chk("s6_done",   {63'd0, done}, 64'd0);
        chk("s6_tdata",  {32'd0, m_axis_tdata}, 64'd0);
        chk("s6_tdest",  {62'd0, m_axis_tdest}, 64'd0);
        ARESET = 1'b0;
        @(posedge tb_ACLK); #1;
        cfgWrite(2'd0, mOrg); cfgWrite(2'd1, mLen);
        clearLog();
        startSweep();
        waitDone("s6", 50);
        if (logD.size() > 0) begin
            chk("s6_replay_data", {32'd0, logD[0]}, 64'h0002_0010);
            chk("s6_replay_dest", {62'd0, logT[0]}, 64'd0);
        end else begin
            chk("s6_replay_count", 64'(logD.size()), 64'(6 + TERM_EXTRA));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
